// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the push-button debounce filter.
// State encoding is one-hot so any other pattern is recognisably illegal.
package key_filter_pkg;

  typedef enum logic [3:0] {
    KF_IDLE    = 4'b0001,
    KF_PRESS_F = 4'b0010,
    KF_HELD    = 4'b0100,
    KF_REL_F   = 4'b1000
  } kf_state_e;

  // Milliseconds to clock cycles (integer kHz first to keep the product small).
  function automatic int unsigned ms2cyc(input int unsigned freq_hz, input int unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// RST_VAL lets the caller preload the inactive level so reset never looks like a press.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: one-clock key_flag per qualified press, debounced key_level,
// and optional hold-to-repeat pulses while the key stays down.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 25_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_level
);

  localparam int unsigned CNT_MAX  = ms2cyc(CLK_FREQ_HZ, DEBOUNCE_MS) - 1;
  localparam int unsigned RPT_DLY  = ms2cyc(CLK_FREQ_HZ, REPEAT_DELAY_MS) - 1;
  localparam int unsigned RPT_RATE = ms2cyc(CLK_FREQ_HZ, REPEAT_RATE_MS) - 1;
  localparam int unsigned CNT_TOP  = max3(CNT_MAX, RPT_DLY, RPT_RATE);
  localparam int unsigned CNT_W    = (CNT_TOP > 0) ? $clog2(CNT_TOP + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RPT_DLY_C  = CNT_W'(RPT_DLY);
  localparam logic [CNT_W-1:0] RPT_RATE_C = CNT_W'(RPT_RATE);
  localparam logic             REL_LVL    = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic key_raw_s;
  logic key_s;

  kf_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic [CNT_W-1:0] rpt_lim;
  logic             phase_q, phase_d;
  logic             key_flag_q, key_flag_d;
  logic             key_level_q, key_level_d;

  sync_2ff #(
    .RST_VAL (REL_LVL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_raw_s)
  );

  // Polarity fix: key_s is 1 while the button is pressed.
  assign key_s = key_raw_s ^ REL_LVL;

  // Next state, counters and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rpt_d       = rpt_q;
    phase_d     = phase_q;
    key_flag_d  = 1'b0;
    key_level_d = key_level_q;
    rpt_lim     = phase_q ? RPT_RATE_C : RPT_DLY_C;

    case (state_q)
      KF_IDLE: begin
        if (key_s) begin
          state_d = KF_PRESS_F;
          cnt_d   = '0;
        end
      end
      KF_PRESS_F: begin
        if (!key_s) begin
          state_d = KF_IDLE;
        end else if (cnt_q == CNT_MAX_C) begin
          state_d     = KF_HELD;
          key_flag_d  = 1'b1;
          key_level_d = 1'b1;
          rpt_d       = '0;
          phase_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KF_HELD: begin
        if (!key_s) begin
          state_d = KF_REL_F;
          cnt_d   = '0;
          rpt_d   = '0;
          phase_d = 1'b0;
        end else if (REPEAT_EN != 0) begin
          // First repeat after the long delay, then at the shorter rate.
          if (rpt_q == rpt_lim) begin
            key_flag_d = 1'b1;
            rpt_d      = '0;
            phase_d    = 1'b1;
          end else begin
            rpt_d = rpt_q + CNT_W'(1);
          end
        end
      end
      KF_REL_F: begin
        if (key_s) begin
          state_d = KF_HELD;
          rpt_d   = '0;
          phase_d = 1'b0;
        end else if (cnt_q == CNT_MAX_C) begin
          state_d     = KF_IDLE;
          key_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = KF_IDLE;
        cnt_d       = '0;
        rpt_d       = '0;
        phase_d     = 1'b0;
        key_level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= KF_IDLE;
      cnt_q       <= '0;
      rpt_q       <= '0;
      phase_q     <= 1'b0;
      key_flag_q  <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rpt_q       <= rpt_d;
      phase_q     <= phase_d;
      key_flag_q  <= key_flag_d;
      key_level_q <= key_level_d;
    end
  end

  assign key_flag  = key_flag_q;
  assign key_level = key_level_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed and random button activity against a run-length
// reference model, with a scoreboard of expected flag pulses and level edges.
module tb_key_filter;

  localparam int QUAL    = 11;  // consecutive synchronized samples needed to qualify
  localparam int LAT     = 13;  // drive-cycle to flag-cycle distance (E0 + 12)
  localparam int RPT_1ST = 20;
  localparam int RPT_GAP = 10;

  typedef struct {
    int cyc;
    bit lvl;
  } lvl_ev_t;

  logic clk;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int      flag_q[$];
  lvl_ev_t lvl_q[$];

  int flag_cnt      = 0;
  int lvl_chg_cnt   = 0;
  int last_flag_cyc = -1;
  int last_fall_cyc = -1;
  int drv_cyc       = 0;

  key_filter #(
    .CLK_FREQ_HZ     (10_000),
    .DEBOUNCE_MS     (1),
    .KEY_ACTIVE_LOW  (1),
    .REPEAT_EN       (1),
    .REPEAT_DELAY_MS (2),
    .REPEAT_RATE_MS  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_level (key_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a press qualifies after QUAL consecutive pressed samples,
  // a release after QUAL consecutive released samples; while held, repeats fire
  // RPT_1ST samples after the last anchor and every RPT_GAP after that.
  bit s1 = 0, s2 = 0, ks = 0, prev_ks = 0, lvl = 0;
  int run0 = 0, run1 = 0, h = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      s1 = 0; s2 = 0; prev_ks = 0; lvl = 0;
      run0 = 0; run1 = 0; h = 0;
    end else begin
      ks = s2;
      s2 = s1;
      s1 = (key_in == 1'b0);
      if (ks) begin run1++; run0 = 0; end
      else    begin run0++; run1 = 0; end
      if (!lvl) begin
        if (ks && run1 == QUAL) begin
          lvl = 1; h = 0;
          flag_q.push_back(cyc);
          lvl_q.push_back('{cyc: cyc, lvl: 1'b1});
        end
      end else if (!ks) begin
        if (run0 == QUAL) begin
          lvl = 0;
          lvl_q.push_back('{cyc: cyc, lvl: 1'b0});
        end
      end else if (!prev_ks) begin
        h = 0;  // key came back during release qualification
      end else begin
        h++;
        if (h >= RPT_1ST && ((h - RPT_1ST) % RPT_GAP) == 0) flag_q.push_back(cyc);
      end
      prev_ks = ks;
    end
  end

  // Monitor: compare DUT pulses and level edges to the expected queues.
  bit prev_flag = 0, prev_lvl = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_flag = 0;
      prev_lvl  = 0;
    end else begin
      while (flag_q.size() > 0 && flag_q[0] < cyc) begin
        chk("flag_missing", -1, flag_q[0]);
        void'(flag_q.pop_front());
      end
      while (lvl_q.size() > 0 && lvl_q[0].cyc < cyc) begin
        chk("level_edge_missing", -1, lvl_q[0].cyc);
        void'(lvl_q.pop_front());
      end
      if (key_flag) begin
        flag_cnt++;
        last_flag_cyc = cyc;
        chk("flag_width", int'(prev_flag), 0);
        if (flag_q.size() == 0) chk("flag_spurious", cyc, -1);
        else chk("flag_cycle", cyc, flag_q.pop_front());
      end
      if (key_level !== prev_lvl) begin
        lvl_chg_cnt++;
        if (!key_level) last_fall_cyc = cyc;
        if (lvl_q.size() == 0) chk("level_spurious", cyc, -1);
        else begin
          lvl_ev_t e;
          e = lvl_q.pop_front();
          chk("level_edge_cycle", cyc, e.cyc);
          chk("level_edge_value", int'(key_level), int'(e.lvl));
        end
      end
      prev_flag = key_flag;
      prev_lvl  = key_level;
    end
  end

  task automatic hold(input bit pressed, input int n);
    key_in  = pressed ? 1'b0 : 1'b1;
    drv_cyc = cyc;
    repeat (n) @(negedge clk);
  endtask

  int fc0, lc0, rc;

  initial begin
    rst_n  = 1'b0;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_flag", int'(key_flag), 0);
    chk("reset_level", int'(key_level), 0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press
    fc0 = flag_cnt;
    hold(1, 15);
    #1;
    chk("s1_flag_cycle", last_flag_cyc, drv_cyc + LAT);
    chk("s1_level", int'(key_level), 1);
    chk("s1_flag_count", flag_cnt - fc0, 1);
    hold(1, 35);
    hold(0, 30);

    // Press bounce: toggle every 3 cycles, then stay pressed
    fc0 = flag_cnt;
    for (int i = 0; i < 12; i++) hold((i % 2) == 0, 3);
    chk("s2_no_flag_bounce", flag_cnt - fc0, 0);
    hold(1, 18);
    #1;
    chk("s2_flag_cycle", last_flag_cyc, drv_cyc + LAT);
    chk("s2_flag_count", flag_cnt - fc0, 1);
    hold(0, 30);

    // Release glitch while held, then clean release
    fc0 = flag_cnt;
    lc0 = lvl_chg_cnt;
    hold(1, 15);
    hold(0, 5);
    hold(1, 10);
    chk("s3_level_held", int'(key_level), 1);
    chk("s3_level_edges", lvl_chg_cnt - lc0, 1);
    chk("s3_flag_count", flag_cnt - fc0, 1);
    hold(0, 15);
    #1;
    chk("s3_fall_cycle", last_fall_cyc, drv_cyc + LAT);
    chk("s3_level_low", int'(key_level), 0);
    hold(0, 10);

    // Auto-repeat over an 80-cycle hold: 12, 32, 42, 52, 62, 72
    fc0 = flag_cnt;
    hold(1, 80);
    hold(0, 20);
    chk("s4_repeat_count", flag_cnt - fc0, 6);

    // Reset while held, key still held at reset release
    hold(1, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_flag", int'(key_flag), 0);
    chk("s5_async_level", int'(key_level), 0);
    repeat (3) @(negedge clk);
    fc0 = flag_cnt;
    #2 rst_n = 1'b1;
    rc = cyc;
    repeat (20) @(negedge clk);
    #1;
    chk("s5_reflag_cycle", last_flag_cyc, rc + LAT);
    chk("s5_reflag_count", flag_cnt - fc0, 1);
    chk("s5_level", int'(key_level), 1);
    hold(0, 30);

    // Random activity mixing short bounces and long holds
    for (int i = 0; i < 60; i++) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 45)));
    hold(0, 40);

    chk("flag_queue_drained", flag_q.size(), 0);
    chk("level_queue_drained", lvl_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
